formula_bist: RTL and testbench
===============================

# formula_bist

Synthesizable traffic generator and result checker for the `formula` block. It drives the operand side of the formula pipeline (`a`, `b`, `c`, `d` with valid/ready) from an LFSR. It records the expected result of every accepted transaction in an internal FIFO and consumes the `q` stream (valid/ready), comparing each result in order. It sits opposite `formula` on both handshakes and provides on-chip self-test with pass/fail and error counts.

## Interface
- `WIDTH`, 8: operand width; must satisfy 4*WIDTH <= 32.
- `NUM_OPS`, 16: number of transactions issued per run (1..65535).
- `DEPTH`, 4: expected-value FIFO depth; a power of two, at least 2.
- `SEED`, 32'hACE1_2024: LFSR start value; must be nonzero.
- `TIMEOUT`, 256: maximum idle cycles in DRAIN before the run aborts.
- `clk` in 1: single clock; all logic on posedge.
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: one-cycle pulse that starts a run; honoured only in IDLE or DONE.
- `a`, `b`, `c`, `d` out WIDTH signed: operands to `formula`.
- `op_valid` out 1: connects to `formula.in_valid`.
- `op_ready` in 1: connects to `formula.in_ready`.
- `q` in WIDTH*2+3 signed: result from `formula`.
- `res_valid` in 1: connects to `formula.out_valid`.
- `res_ready` out 1: connects to `formula.out_ready`.
- `busy` out 1: high in RUN and DRAIN.
- `done` out 1: high in DONE.
- `pass` out 1: meaningful only while `done` is high.
- `err_count` out 16: number of mismatched or unexpected results; saturates at 16'hFFFF.
- `res_count` out 16: number of results consumed in the current run.

## Operation
- FSM states and transitions:
  - IDLE → RUN on `start`. The same transition clears the counters and error flags and reloads the LFSR with `SEED`.
  - RUN → DRAIN when `NUM_OPS` operand handshakes have completed.
  - DRAIN → DONE when the FIFO is empty.
  - DRAIN → DONE with `timeout_flag` set when `TIMEOUT` consecutive cycles pass with no result handshake.
  - DONE → RUN on `start`, with the same clearing as from IDLE.
- LFSR: 32-bit Galois, feedback mask 32'h8020_0003, shifted once per accepted operand handshake.
- Operand mapping: `a`=lfsr[WIDTH-1:0], `b`=lfsr[2W-1:W], `c`=lfsr[3W-1:2W], `d`=lfsr[4W-1:3W].
- Operand handshake: fires when `op_valid && op_ready`.
- `op_valid` is asserted in RUN only when the FIFO has room: occupancy < DEPTH, with a same-cycle pop counted as freeing a slot.
- While `op_valid` is high and `op_ready` is low, operands and `op_valid` are held stable.
- Expected value is computed at operand handshake, in WIDTH*2+3-bit signed arithmetic: ((a-b)*(1+3c)+4d) >>> 1, arithmetic shift.
- The expected value is pushed into the FIFO on the same edge as the operand handshake.
- Result handshake: fires when `res_valid && res_ready`. It pops the FIFO head and compares it with `q`. A mismatch increments `err_count`.
- A result handshake with the FIFO empty also increments `err_count` and sets `unexpected_flag`. Nothing is popped.
- A push and a pop in the same cycle are both performed; occupancy is unchanged.
- `pass` = (`err_count`==0) && !`timeout_flag` && !`unexpected_flag`, with `res_count`==`NUM_OPS`.
- Results arriving in IDLE or DONE are ignored: `res_ready`=0.

## Timing
- Reset value of every output is 0: `a`, `b`, `c`, `d`, `op_valid`, `res_ready`, `busy`, `done`, `pass`, `err_count`, `res_count`.
- Internal FIFO and flags are also cleared by reset.
- All outputs are registered, except `res_ready`, which is combinational from state and the stall LFSR bit.
- `op_valid` rises on the first edge after the `start` edge.
- Back-to-back issue is one transaction per cycle while `op_ready`=1 and the FIFO is not full.
- A compare result is visible in `err_count` one cycle after the result handshake.
- `done` rises on the edge after the last pop.
- Reset mid-run: returns to IDLE on the next edge with all state cleared. Results still in flight in `formula` are dropped because `res_ready`=0.
- `start` in RUN or DRAIN is ignored.

## Configuration
- `FORMULA_BIST_STALL_EN` defined: in RUN and DRAIN, `res_ready` is driven low whenever LFSR bit 31 is 1, to exercise backpressure.
- `FORMULA_BIST_STALL_EN` undefined: `res_ready` is 1 throughout RUN and DRAIN.

## Structure
- Package `formula_pkg` holds:
  - `state_t` enum {IDLE, RUN, DRAIN, DONE};
  - the LFSR mask constant;
  - the function `formula_ref(a,b,c,d)` returning the expected value, shared with the bench scoreboard.
- Sub-module `formula_bist_fifo`: synchronous FIFO, parameterized by width and depth, with `full`/`empty` flags and simultaneous push/pop.

## Test plan
- `formula_bist` connected to `formula`, `NUM_OPS`=10, `start` pulse → `done`=1, `pass`=1, `res_count`=10, `err_count`=0.
- `formula_ref` spot checks:
  - a=5, b=2, c=1, d=3 → 12.
  - a=-128, b=127, c=-128, d=-128 → 48576.
- Responder stub that inverts bit 0 of the third `q` → `err_count`=1, `pass`=0, `done`=1.
- Stub that holds `op_ready`=0 for 5 cycles → operands and `op_valid` stable throughout; no LFSR advance.
- `DEPTH`=2 with a stub returning no results → `op_valid` drops after 2 handshakes; after 256 idle cycles, `done`=1 and `pass`=0.
- Reset asserted during RUN after 4 handshakes → next cycle all outputs 0; a new `start` reproduces the first-run operand sequence from `SEED`.

Source files
------------

// File: rtl/formula_pkg.sv
// formula_pkg: shared types, LFSR constant and the reference model of the
// formula pipeline, used by formula_bist and by its testbench scoreboard.
// Contents: state_t, LFSR_MASK, REF_WIDTH, formula_ref().
package formula_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  // Galois feedback taps for the 32-bit operand generator.
  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

  // Result width for 8-bit operands (WIDTH*2+3).
  localparam int REF_WIDTH = 19;

  // ((a-b)*(1+3c)+4d) >>> 1 evaluated in rw-bit signed arithmetic. The sum is
  // formed in 32 bits, wrapped to rw bits, then shifted, so that the sign bit
  // used by the arithmetic shift is the one a real rw-bit datapath would see.
  function automatic logic signed [31:0] formula_ref(
    input logic signed [31:0] a,
    input logic signed [31:0] b,
    input logic signed [31:0] c,
    input logic signed [31:0] d,
    input int                 rw = REF_WIDTH
  );
    logic signed [31:0] s;
    int                 sh;
    sh = 32 - rw;
    s  = (a - b) * (32'sd1 + 32'sd3 * c) + 32'sd4 * d;
    s  = (s <<< sh) >>> sh;
    return s >>> 1;
  endfunction

endpackage

// File: rtl/formula_bist_fifo.sv
// Purpose: synchronous FIFO holding expected results for formula_bist.
// Latency: pushed word is visible at pop_dat the cycle after the push edge.
// Backpressure: push ignored when full unless a pop frees the slot the same cycle.
// Ports: clk, rst_n (sync, active-low), clr (sync flush), push/push_dat,
//        pop/pop_dat (head, combinational read), full, empty, count.
module formula_bist_fifo #(
  parameter int W     = 19,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     push,
  input  logic [W-1:0]             push_dat,
  input  logic                     pop,
  output logic [W-1:0]             pop_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/formula_bist.sv
// Purpose: LFSR traffic generator and in-order result checker for formula.
// Latency: op_valid one cycle after the start edge; err_count one cycle after a result handshake.
// Backpressure: operands held while op_ready=0; issue throttled by expected-FIFO room.
// Ports: clk, rst_n (sync, active-low), start; a/b/c/d, op_valid, op_ready
//        (operand side); q, res_valid, res_ready (result side); busy, done,
//        pass, err_count, res_count (status).
// Option: define FORMULA_BIST_STALL_EN to drop res_ready whenever LFSR bit 31 is 1.
module formula_bist
  import formula_pkg::*;
#(
  parameter int          WIDTH   = 8,
  parameter int          NUM_OPS = 16,
  parameter int          DEPTH   = 4,
  parameter logic [31:0] SEED    = 32'hACE1_2024,
  parameter int          TIMEOUT = 256
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  output logic signed [WIDTH-1:0]   a,
  output logic signed [WIDTH-1:0]   b,
  output logic signed [WIDTH-1:0]   c,
  output logic signed [WIDTH-1:0]   d,
  output logic                      op_valid,
  input  logic                      op_ready,
  input  logic signed [WIDTH*2+2:0] q,
  input  logic                      res_valid,
  output logic                      res_ready,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic [15:0]               err_count,
  output logic [15:0]               res_count
);

  localparam int RW = WIDTH*2 + 3;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  state_t             state;
  logic [31:0]        lfsr;
  logic [31:0]        lfsr_next;
  logic [15:0]        issue_cnt;
  logic [TW-1:0]      idle_cnt;
  logic               timeout_flag;
  logic               unexpected_flag;
  logic               stall;
  logic               op_hs;
  logic               res_hs;
  logic               fifo_pop;
  logic               fifo_clr;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CW-1:0]      fifo_count;
  logic [RW-1:0]      exp_val;
  logic [RW-1:0]      fifo_head;
  logic               mismatch;
  logic               room_next;
  logic signed [31:0] ref32;
  logic               unused_ref_hi;

  // Operands are taken straight from the LFSR register, so they only move
  // when the LFSR steps on an accepted handshake.
  assign a = lfsr[WIDTH-1:0];
  assign b = lfsr[2*WIDTH-1:WIDTH];
  assign c = lfsr[3*WIDTH-1:2*WIDTH];
  assign d = lfsr[4*WIDTH-1:3*WIDTH];

  assign lfsr_next = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? LFSR_MASK : 32'h0);

`ifdef FORMULA_BIST_STALL_EN
  assign stall = lfsr[31];
`else
  assign stall = 1'b0;
`endif

  assign res_ready = ((state == RUN) || (state == DRAIN)) && !stall;
  assign op_hs     = op_valid && op_ready;
  assign res_hs    = res_valid && res_ready;
  assign fifo_pop  = res_hs && !fifo_empty;
  assign fifo_clr  = start && ((state == IDLE) || (state == DONE));
  assign mismatch  = res_hs && (fifo_empty || (q != fifo_head));

  assign ref32         = formula_ref(32'(a), 32'(b), 32'(c), 32'(d), RW);
  assign exp_val       = ref32[RW-1:0];
  assign unused_ref_hi = ^ref32[31:RW];

  // FIFO will still have room after this edge: a pop in the same cycle frees
  // a slot, a push consumes one.
  assign room_next = !((fifo_full && !fifo_pop) ||
                       ((fifo_count == CW'(DEPTH-1)) && op_hs && !fifo_pop));

  formula_bist_fifo #(.W(RW), .DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (fifo_clr),
    .push     (op_hs),
    .push_dat (exp_val),
    .pop      (fifo_pop),
    .pop_dat  (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      lfsr            <= '0;
      issue_cnt       <= '0;
      idle_cnt        <= '0;
      timeout_flag    <= 1'b0;
      unexpected_flag <= 1'b0;
      op_valid        <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_count       <= '0;
      res_count       <= '0;
    end else begin
      if (res_hs) begin
        res_count <= res_count + 16'd1;
        if (mismatch && (err_count != 16'hFFFF)) err_count <= err_count + 16'd1;
        if (fifo_empty) unexpected_flag <= 1'b1;
      end

      case (state)
        IDLE, DONE: begin
          if (start) begin
            state           <= RUN;
            lfsr            <= SEED;
            issue_cnt       <= '0;
            idle_cnt        <= '0;
            timeout_flag    <= 1'b0;
            unexpected_flag <= 1'b0;
            err_count       <= '0;
            res_count       <= '0;
            busy            <= 1'b1;
            done            <= 1'b0;
            pass            <= 1'b0;
          end
        end

        RUN: begin
          idle_cnt <= '0;
          if (op_hs) begin
            lfsr      <= lfsr_next;
            issue_cnt <= issue_cnt + 16'd1;
          end
          if (op_hs && (issue_cnt == 16'(NUM_OPS-1))) begin
            state    <= DRAIN;
            op_valid <= 1'b0;
          end else begin
            op_valid <= room_next;
          end
        end

        DRAIN: begin
          // Leaving only on a quiet cycle keeps every counter final when
          // pass is evaluated.
          if (res_hs) begin
            idle_cnt <= '0;
          end else if (fifo_empty) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_count == 16'd0) && !timeout_flag && !unexpected_flag &&
                     (res_count == 16'(NUM_OPS));
          end else if (idle_cnt == TW'(TIMEOUT-1)) begin
            state        <= DONE;
            timeout_flag <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b1;
            pass         <= 1'b0;
          end else begin
            idle_cnt <= idle_cnt + TW'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_formula_bist.sv
// Testbench for formula_bist: a behavioural formula responder on the main
// instance, a silent responder on a second DEPTH=2 instance for the timeout
// path, plus a vector table for the shared reference function.
module tb_formula_bist;
  import formula_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic op_ready;
  logic signed [7:0]  a, b, c, d;
  logic               op_valid;
  logic signed [18:0] q;
  logic               res_valid;
  logic               res_ready, busy, done, pass;
  logic [15:0]        err_count, res_count;

  logic               start2;
  logic signed [7:0]  a2, b2, c2, d2;
  logic               op_valid2, res_ready2, busy2, done2, pass2;
  logic [15:0]        err_count2, res_count2;

  always #5 clk = ~clk;

  formula_bist #(.WIDTH(8), .NUM_OPS(10), .DEPTH(4), .SEED(32'hACE1_2024), .TIMEOUT(256)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a(a), .b(b), .c(c), .d(d),
    .op_valid(op_valid), .op_ready(op_ready),
    .q(q), .res_valid(res_valid), .res_ready(res_ready),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .res_count(res_count)
  );

  formula_bist #(.WIDTH(8), .NUM_OPS(2), .DEPTH(2), .SEED(32'hACE1_2024), .TIMEOUT(256)) u_to (
    .clk(clk), .rst_n(rst_n), .start(start2),
    .a(a2), .b(b2), .c(c2), .d(d2),
    .op_valid(op_valid2), .op_ready(1'b1),
    .q(19'sd0), .res_valid(1'b0), .res_ready(res_ready2),
    .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err_count2), .res_count(res_count2)
  );

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] lfsr_step(input logic [31:0] x);
    return (x >> 1) ^ (x[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  // ---------------- responder for u_dut ----------------
  logic signed [18:0] resp_q[$];
  logic [31:0]        op_log  [64];
  int                 op_edge [64];
  int hs_cnt = 0, ret_cnt = 0, corrupt_idx = 0, corrupt_edge = -1, last_res_edge = -1;

  initial begin
    q = '0;
    res_valid = 1'b0;
  end

  always begin : responder
    logic               of, rf;
    logic signed [7:0]  sa, sb, sc, sd;
    logic signed [31:0] r32;
    logic signed [18:0] tmp;
    @(negedge clk); #2;
    of = rst_n && op_valid && op_ready;
    rf = rst_n && res_valid && res_ready;
    if (!rst_n) resp_q.delete();
    sa = a; sb = b; sc = c; sd = d;
    if (of) begin
      if (hs_cnt < 64) begin
        op_log[hs_cnt]  = {d, c, b, a};
        op_edge[hs_cnt] = cyc + 1;
      end
      hs_cnt++;
    end
    if (rf) begin
      if (ret_cnt + 1 == corrupt_idx) corrupt_edge = cyc + 1;
      ret_cnt++;
      last_res_edge = cyc + 1;
    end
    @(posedge clk); #1;
    if (rf && resp_q.size() > 0) tmp = resp_q.pop_front();
    if (of) begin
      r32 = formula_ref(32'(sa), 32'(sb), 32'(sc), 32'(sd));
      resp_q.push_back(r32[18:0]);
    end
    res_valid = (resp_q.size() > 0);
    if (resp_q.size() > 0)
      q = resp_q[0] ^ ((ret_cnt + 1 == corrupt_idx) ? 19'sd1 : 19'sd0);
    else
      q = '0;
  end

  // ---------------- helpers ----------------
  int done_cyc, err_cyc;

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    done_cyc = -1;
    err_cyc  = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (err_cyc < 0 && err_count != 0) err_cyc = cyc;
      if (done) begin
        done_cyc = cyc;
        break;
      end
    end
    check("done_reached", done, 1);
  endtask

  task automatic wait_hs(input int n);
    for (int i = 0; i < 100; i++) begin
      if (hs_cnt >= n) break;
      @(negedge clk); #1;
    end
    check("hs_reached", hs_cnt >= n, 1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_a"}, 32'(unsigned'(a)), 0);
    check({tag, "_b"}, 32'(unsigned'(b)), 0);
    check({tag, "_c"}, 32'(unsigned'(c)), 0);
    check({tag, "_d"}, 32'(unsigned'(d)), 0);
    check({tag, "_op_valid"}, op_valid, 0);
    check({tag, "_res_ready"}, res_ready, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pass"}, pass, 0);
    check({tag, "_err_count"}, err_count, 0);
    check({tag, "_res_count"}, res_count, 0);
  endtask

  task automatic check_seq(input string tag);
    logic [31:0] x;
    x = 32'hACE1_2024;
    for (int i = 0; i < 10; i++) begin
      check($sformatf("%s_ops%0d", tag, i), op_log[i], x);
      x = lfsr_step(x);
    end
  endtask

  task automatic clear_log();
    hs_cnt = 0; ret_cnt = 0; corrupt_edge = -1; last_res_edge = -1;
    for (int i = 0; i < 64; i++) begin
      op_log[i] = 'x; op_edge[i] = -1;
    end
  endtask

  typedef struct { int a; int b; int c; int d; int exp; } fvec_t;
  fvec_t ftab [12];

  initial begin
    logic signed [31:0] r;
    int to_hs, to_last, to_done;

    ftab[0]  = '{5, 2, 1, 3, 12};
    ftab[1]  = '{-128, 127, -128, -128, 48576};
    ftab[2]  = '{0, 0, 0, 0, 0};
    ftab[3]  = '{0, 0, 0, 1, 2};
    ftab[4]  = '{0, 0, 0, -1, -2};
    ftab[5]  = '{1, 0, 0, 0, 0};
    ftab[6]  = '{-1, 0, 0, 0, -1};
    ftab[7]  = '{127, -128, 127, 127, 48959};
    ftab[8]  = '{3, 5, -1, 0, 2};
    ftab[9]  = '{-128, 127, 127, -128, -48961};
    ftab[10] = '{10, 3, 2, -5, 14};
    ftab[11] = '{0, 1, 0, 0, -1};

    rst_n = 1'b0; start = 1'b0; start2 = 1'b0; op_ready = 1'b1;
    clear_log();
    @(negedge clk); #1;
    @(negedge clk); #1;
    @(negedge clk); #1;
    rst_n = 1'b1;
    check_zero("reset");
    check("reset_done2", done2, 0);

    // Reference function vectors.
    for (int i = 0; i < 12; i++) begin
      r = formula_ref(ftab[i].a, ftab[i].b, ftab[i].c, ftab[i].d);
      check($sformatf("ref%0d", i), r, ftab[i].exp);
    end

    // Normal run, 10 operations, back-to-back.
    clear_log();
    pulse_start();
    check("run_busy", busy, 1);
    check("run_op_valid_late", op_valid, 0);
    check("run_res_ready", res_ready, 1);
    @(negedge clk); #1;
    check("run_op_valid", op_valid, 1);
    check("run_first_ops", {d, c, b, a}, 32'hACE1_2024);
    wait_done(200);
    check("run_pass", pass, 1);
    check("run_res_count", res_count, 10);
    check("run_err_count", err_count, 0);
    check("run_busy_end", busy, 0);
    check("run_hs_cnt", hs_cnt, 10);
    check("run_b2b", op_edge[9] - op_edge[0], 9);
    check("run_done_edge", done_cyc, last_res_edge + 1);
    check("run_second_ops", op_log[1], 32'h5670_9012);
    check_seq("run");

    // Third result corrupted by one bit.
    clear_log();
    corrupt_idx = 3;
    pulse_start();
    wait_done(200);
    check("bad_err_count", err_count, 1);
    check("bad_pass", pass, 0);
    check("bad_done", done, 1);
    check("bad_res_count", res_count, 10);
    check("bad_err_timing", err_cyc, corrupt_edge);
    corrupt_idx = 0;

    // op_ready held low for 5 cycles: operands frozen at the seed.
    clear_log();
    op_ready = 1'b0;
    pulse_start();
    @(negedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("hold_op_valid%0d", i), op_valid, 1);
      check($sformatf("hold_ops%0d", i), {d, c, b, a}, 32'hACE1_2024);
      check($sformatf("hold_hs%0d", i), hs_cnt, 0);
      @(negedge clk); #1;
    end
    op_ready = 1'b1;
    wait_done(200);
    check("hold_pass", pass, 1);
    check("hold_first_ops", op_log[0], 32'hACE1_2024);

    // Reset after 4 handshakes, then a rerun from the seed with a stray start.
    clear_log();
    pulse_start();
    wait_hs(4);
    rst_n = 1'b0;
    @(negedge clk); #1;
    check_zero("midrst");
    check("midrst_hs", hs_cnt, 4);
    rst_n = 1'b1;
    clear_log();
    pulse_start();
    wait_hs(5);
    pulse_start();
    check("rerun_busy", busy, 1);
    wait_done(200);
    check("rerun_pass", pass, 1);
    check("rerun_res_count", res_count, 10);
    check("rerun_hs_cnt", hs_cnt, 10);
    check_seq("rerun");

    // Second instance: DEPTH=2, no results ever come back.
    to_hs = 0; to_last = -1; to_done = -1;
    start2 = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); #1;
      start2 = 1'b0;
      if (op_valid2) begin
        to_hs++;
        to_last = cyc + 1;
      end
      if (done2) begin
        to_done = cyc;
        break;
      end
    end
    check("to_hs", to_hs, 2);
    check("to_done", done2, 1);
    check("to_done_edge", to_done, to_last + 256);
    check("to_pass", pass2, 0);
    check("to_busy", busy2, 0);
    check("to_op_valid", op_valid2, 0);
    check("to_err_count", err_count2, 0);
    check("to_res_count", res_count2, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
